uart_receiver: RTL and testbench

- 16x-oversampling UART receive path.
- Consumes the one-CLK oversample tick from the baud tick generator (100 MHz / 651 gives 16 x 9600 baud).
- Deserialises an 8N1 (parameterisable) asynchronous serial line into parallel bytes for the gripper command parser.
- Flags framing errors.

---
 rtl/uart_pkg.sv | 9 +
 rtl/rx_line_sync.sv | 39 +++
 rtl/uart_receiver.sv | 119 +++++++++++
 tb/tb_uart_receiver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampling UART receive path.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int OVS         = 16;
  localparam int HALF_OVS    = 7;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
endpackage

// File: rtl/rx_line_sync.sv
// Two-flop synchroniser plus delay flop for the serial line; 2-CLK latency to rx_s.
// No backpressure: free-running, resets to line-high.
module rx_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       dly_q, dly_d;
  logic [2:0] prime_q, prime_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    prime_d = {prime_q[1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
      prime_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      prime_q <= prime_d;
    end
  end

  assign rx_s = sync2_q;
  // The reset-high pipeline would fake an edge on a line already low; wait until dly_q holds a real sample.
  assign fall_edge = prime_q[2] & dly_q & ~sync2_q;
endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: rx_done pulses one CLK after the final stop tick.
// No backpressure: rx_data is held until the next completed frame overwrites it.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done,
  output logic            frame_err,
  output logic            busy
);
  logic rx_s;
  logic fall_edge;

  state_e            state_q, state_d;
  logic [4:0]        s_cnt_q, s_cnt_d;
  logic [2:0]        n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]   b_reg_q, b_reg_d;
  logic [DBIT-1:0]   rx_data_q, rx_data_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;

  rx_line_sync u_sync (
    .clk       (CLK),
    .reset     (RESET),
    .rx        (rx),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    b_reg_d     = b_reg_q;
    rx_data_d   = rx_data_q;
    frame_err_d = frame_err_q;
    rx_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == 5'(HALF_OVS)) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == 5'(OVS - 1)) begin
            b_reg_d = {rx_s, b_reg_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == 3'(DBIT - 1)) state_d = STOP;
            else                         n_cnt_d = n_cnt_q + 3'd1;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == 5'(SB_TICK - 1)) begin
            rx_data_d   = b_reg_q;
            frame_err_d = ~rx_s;
            rx_done_d   = 1'b1;
            state_d     = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      b_reg_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      b_reg_q     <= b_reg_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table of frames plus hand sequences for glitch, break and mid-frame reset.
module tb_uart_receiver;
  logic       CLK;
  logic       RESET;
  logic       rx;
  logic       s_tick;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_receiver #(.DBIT(8), .SB_TICK(16)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .rx        (rx),
    .s_tick    (s_tick),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_ferr;
    int         gap;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];

  int   tests;
  int   fails;
  int   done_cnt;
  int   tick_div;
  int   base;
  logic last_tick;
  logic prev_done;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One CLK: sample outputs on the falling edge, score any rx_done, then advance the 1-in-4 tick.
  task automatic step();
    exp_t e;
    @(negedge CLK);
    last_tick = s_tick;
    if (rx_done) begin
      done_cnt++;
      check("done_width", prev_done, 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got rx_done data %0h with no frame expected at %0t", rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.data);
        check("frame_err", frame_err, e.ferr);
      end
    end
    prev_done = rx_done;
    tick_div  = (tick_div + 1) % 4;
    s_tick    = (tick_div == 0);
  endtask

  task automatic wait_ticks(input int n);
    int cnt;
    cnt = 0;
    while (cnt < n) begin
      step();
      if (last_tick) cnt++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic eferr);
    exp_t e;
    e.data = d;
    e.ferr = eferr;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_ticks(16);
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(16);
    rx = 1'b1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    done_cnt  = 0;
    tick_div  = 0;
    last_tick = 1'b0;
    prev_done = 1'b0;
    RESET     = 1'b1;
    rx        = 1'b1;
    s_tick    = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 8};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 16};
    vecs[4] = '{8'h11, 1'b1, 1'b0, 8};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 0};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 8};

    repeat (3) step();
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_done", rx_done, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    RESET = 1'b0;
    wait_ticks(8);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      base = done_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].exp_ferr);
      if (vecs[i].gap > 0) begin
        wait_ticks(vecs[i].gap);
        check("busy_after_frame", busy, 0);
      end
      check("done_count", done_cnt - base, 1);
    end

    // Short low pulse: start-bit midpoint sees high, frame is rejected.
    base = done_cnt;
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(2);
    check("glitch_busy_hold", busy, 1);
    wait_ticks(3);
    check("glitch_busy_drop", busy, 0);
    wait_ticks(16);
    check("glitch_no_done", done_cnt - base, 0);

    // Break: one all-zero frame with framing error, then silence until a fresh edge.
    base = done_cnt;
    begin
      exp_t e;
      e.data = 8'h00;
      e.ferr = 1'b1;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    wait_ticks(30 * 16);
    check("break_one_done", done_cnt - base, 1);
    check("break_busy", busy, 0);
    rx = 1'b1;
    wait_ticks(32);
    check("break_no_extra", done_cnt - base, 1);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_ticks(8);
    check("after_break_done", done_cnt - base, 2);

    // Reset during data bit 3, released with the line still low.
    base = done_cnt;
    rx = 1'b0;
    wait_ticks(16 + 3 * 16 + 8);
    RESET = 1'b1;
    step();
    check("midreset_busy", busy, 0);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_frame_err", frame_err, 0);
    RESET = 1'b0;
    wait_ticks(16 * 6);
    check("low_after_reset_idle", busy, 0);
    rx = 1'b1;
    wait_ticks(32);
    check("midreset_no_done", done_cnt - base, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_ticks(8);
    check("after_reset_done", done_cnt - base, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
